// File: rtl/ir_nec_rx_if.sv
// ir_nec_rx_if: Wishbone slave slot bundle for the NEC IR receiver
interface ir_nec_rx_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic        adr_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  modport master(output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i, input dat_o, ack_o);
  modport slave(input cyc_i, stb_i, we_i, adr_i, sel_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/ir_nec_rx.sv
// ir_nec_rx: NEC IR frame decoder feeding a 4-deep frame FIFO behind a Wishbone slave
module ir_nec_rx #(
  parameter int clkfreq = 100000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ir_nec_rx_if.slave  bus,
  input  logic        irda,
  output logic        interrupt
);
  localparam int DIV = clkfreq / 100000;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [2:0] IDLE = 3'd0, LEAD_LO = 3'd1, LEAD_HI = 3'd2, BIT_LO = 3'd3, BIT_HI = 3'd4, STOP = 3'd5;
  logic [1:0]    sync_q;
  logic          prev_q, fall, rise, tick;
  logic [PW-1:0] pre_q;
  logic [11:0]   width_q;
  logic          lead_ok, data_hi, rpt_hi, burst_ok, one_ok;
  logic [2:0]    state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [31:0]   frame_q, frame_d, pframe_q;
  logic          rpt_q, rpt_d, err_set, rpt_inc, push_d, push_q;
  logic [31:0]   mem_q [4];
  logic [1:0]    wp_q, rp_q;
  logic [2:0]    cnt_q;
  logic          ie_q, err_q, ovf_q;
  logic [7:0]    rcnt_q;
  logic          acc, rd, wr_st, pop, wr;
  logic [31:0]   status;
  logic          unused;
  assign unused = ^{bus.sel_i, bus.dat_i[31:7], bus.dat_i[2:0]};
  assign fall = prev_q & ~sync_q[1];
  assign rise = ~prev_q & sync_q[1];
  assign tick = pre_q == PW'(DIV - 1);
  assign lead_ok  = width_q >= 12'd800 && width_q <= 12'd1000;
  assign data_hi  = width_q >= 12'd400 && width_q <= 12'd500;
  assign rpt_hi   = width_q >= 12'd180 && width_q <= 12'd270;
  assign burst_ok = width_q >= 12'd40 && width_q <= 12'd70;
  assign one_ok   = width_q >= 12'd140 && width_q <= 12'd200;
  assign acc = bus.cyc_i & bus.stb_i & ~bus.ack_o;
  assign rd = acc & ~bus.we_i;
  assign wr_st = acc & bus.we_i & bus.adr_i;
  assign pop = rd & ~bus.adr_i & (cnt_q != 3'd0);
  assign wr = push_q & (~cnt_q[2] | pop);
  assign status = {16'h0, rcnt_q, 2'b0, ie_q, err_q, ovf_q, cnt_q};
  assign interrupt = ie_q & (cnt_q != 3'd0);
  // Synchronize the pin, track the previous level, run the 10 us tick and the pulse width counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      pre_q   <= '0;
      width_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], irda};
      prev_q  <= sync_q[1];
      pre_q   <= tick ? '0 : pre_q + 1'b1;
      width_q <= (rise | fall) ? 12'd0 : (tick && width_q != 12'hFFF) ? width_q + 12'd1 : width_q;
    end
  end
  // Frame decoder: judges the width that just ended at every synced edge
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    rpt_d   = rpt_q;
    err_set = 1'b0;
    rpt_inc = 1'b0;
    push_d  = 1'b0;
    if (state_q != IDLE && width_q >= 12'd1200) begin
      state_d = IDLE;
      err_set = state_q != LEAD_LO;
    end else begin
      case (state_q)
        IDLE:    state_d = fall ? LEAD_LO : IDLE;
        LEAD_LO: state_d = rise ? (lead_ok ? LEAD_HI : IDLE) : LEAD_LO;
        LEAD_HI: if (fall) begin
          state_d = data_hi ? BIT_LO : rpt_hi ? STOP : IDLE;
          rpt_d   = rpt_hi & ~data_hi;
          idx_d   = 5'd0;
          err_set = ~data_hi & ~rpt_hi;
        end
        BIT_LO: if (rise) begin
          state_d = burst_ok ? BIT_HI : IDLE;
          err_set = ~burst_ok;
        end
        BIT_HI: if (fall) begin
          frame_d[idx_q] = one_ok;
          idx_d   = idx_q + 5'd1;
          state_d = ~(burst_ok | one_ok) ? IDLE : (idx_q == 5'd31) ? STOP : BIT_LO;
          err_set = ~(burst_ok | one_ok);
        end
        STOP: if (rise) begin
          state_d = IDLE;
          rpt_inc = burst_ok & rpt_q;
          push_d  = burst_ok & ~rpt_q & (frame_q[31:24] == ~frame_q[23:16]);
          err_set = ~burst_ok | (~rpt_q & (frame_q[31:24] != ~frame_q[23:16]));
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Decoder state plus a one-cycle staging register for completed frames
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      frame_q  <= '0;
      rpt_q    <= 1'b0;
      push_q   <= 1'b0;
      pframe_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      rpt_q    <= rpt_d;
      push_q   <= push_d;
      pframe_q <= frame_q;
    end
  end
  // FIFO storage needs no reset; the pointers and count define validity
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wp_q] <= pframe_q;
  end
  // FIFO pointers, status flags and the bus response; hardware sets beat CPU clears
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      ie_q      <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rcnt_q    <= '0;
      bus.ack_o <= 1'b0;
      bus.dat_o <= '0;
    end else begin
      wp_q      <= wp_q + {1'b0, wr};
      rp_q      <= rp_q + {1'b0, pop};
      cnt_q     <= cnt_q + {2'b0, wr} - {2'b0, pop};
      ie_q      <= wr_st ? bus.dat_i[5] : ie_q;
      err_q     <= err_set | (err_q & ~(wr_st & bus.dat_i[4]));
      ovf_q     <= (push_q & cnt_q[2] & ~pop) | (ovf_q & ~(wr_st & bus.dat_i[3]));
      rcnt_q    <= rpt_inc ? rcnt_q + {7'd0, rcnt_q != 8'hFF} : (wr_st & bus.dat_i[6]) ? 8'd0 : rcnt_q;
      bus.ack_o <= acc;
      if (rd) bus.dat_o <= bus.adr_i ? status : (cnt_q != 3'd0) ? mem_q[rp_q] : 32'd0;
    end
  end
endmodule

// File: tb/tb_ir_nec_rx.sv
// tb_ir_nec_rx: randomized NEC frames against a frame-level queue model of the receiver
module tb_ir_nec_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irda = 1'b1;
  logic intr;
  ir_nec_rx_if bus();
  ir_nec_rx #(.clkfreq(100000)) dut (.clk_i(clk), .rst_i(rst), .bus(bus), .irda(irda), .interrupt(intr));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] q[$];
  logic m_ie = 1'b0, m_err = 1'b0, m_ovf = 1'b0;
  logic [7:0] m_rpt = 8'd0;
  logic [31:0] rd, raw;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] st_exp();
    return {16'h0, m_rpt, 2'b0, m_ie, m_err, m_ovf, 3'(q.size())};
  endfunction
  function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bus_xfer(input logic we, input logic a, input logic [31:0] wd, output logic [31:0] r);
    int n = 0;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we; bus.adr_i = a; bus.dat_i = wd;
    do begin idle(1); n++; end while (!bus.ack_o && n < 8);
    chk("ack_seen", 32'(bus.ack_o), 32'd1);
    r = bus.dat_o;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    idle(1);
    chk("ack_single", 32'(bus.ack_o), 32'd0);
  endtask
  task automatic rd_status(input string tag);
    bus_xfer(1'b0, 1'b1, 32'd0, rd);
    chk(tag, rd, st_exp());
  endtask
  task automatic rd_data(input string tag);
    logic [31:0] e;
    e = q.size() != 0 ? q.pop_front() : 32'd0;
    bus_xfer(1'b0, 1'b0, 32'd0, rd);
    chk(tag, rd, e);
  endtask
  task automatic wr_status(input logic [31:0] d);
    bus_xfer(1'b1, 1'b1, d, rd);
    m_ie = d[5];
    if (d[3]) m_ovf = 1'b0;
    if (d[4]) m_err = 1'b0;
    if (d[6]) m_rpt = 8'd0;
  endtask
  task automatic pulse(input logic lvl, input int n);
    irda = lvl;
    idle(n);
  endtask
  task automatic leader(input logic is_rpt);
    pulse(1'b0, $urandom_range(805, 820));
    pulse(1'b1, is_rpt ? $urandom_range(200, 215) : $urandom_range(405, 415));
  endtask
  task automatic send_bits(input logic [31:0] r, input int nb);
    for (int i = 0; i < nb; i++) begin
      pulse(1'b0, $urandom_range(44, 50));
      pulse(1'b1, r[i] ? $urandom_range(143, 150) : $urandom_range(44, 50));
    end
  endtask
  task automatic send_frame(input logic [31:0] r);
    leader(1'b0);
    send_bits(r, 32);
    pulse(1'b0, $urandom_range(44, 50));
    irda = 1'b1;
  endtask
  task automatic send_repeat();
    leader(1'b1);
    pulse(1'b0, $urandom_range(44, 50));
    irda = 1'b1;
  endtask
  task automatic model_push(input logic [31:0] r);
    if (q.size() < 4) q.push_back(r);
    else m_ovf = 1'b1;
  endtask
  initial begin
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.adr_i = 1'b0; bus.sel_i = 4'hF; bus.dat_i = 32'd0;
    idle(3);
    chk("rst_ack", 32'(bus.ack_o), 32'd0);
    chk("rst_dat", bus.dat_o, 32'd0);
    chk("rst_int", 32'(intr), 32'd0);
    rst = 1'b0;
    idle(2);
    rd_status("rst_status");
    wr_status(32'h20);
    send_frame(32'hBA45FF00);
    model_push(32'hBA45FF00);
    idle(3);
    chk("int_early", 32'(intr), 32'd0);
    idle(1);
    chk("int_rise", 32'(intr), 32'd1);
    idle(20);
    for (int i = 0; i < 3; i++) begin
      send_repeat();
      idle(20);
      m_rpt++;
    end
    rd_status("rpt_status");
    chk("int_hold", 32'(intr), 32'd1);
    rd_data("data_first");
    chk("int_fall", 32'(intr), 32'd0);
    rd_status("empty_status");
    rd_data("empty_data");
    wr_status(32'h60);
    rd_status("rpt_clear");
    for (int i = 0; i < 5; i++) begin
      raw = mk(8'($urandom), 8'($urandom));
      send_frame(raw);
      model_push(raw);
      idle(20);
    end
    rd_status("ovf_status");
    chk("int_full", 32'(intr), 32'd1);
    for (int i = 0; i < 4; i++) rd_data("ovf_data");
    wr_status(32'h28);
    rd_status("ovf_clear");
    send_frame(32'hBB45FF00);
    idle(20);
    m_err = 1'b1;
    rd_status("bad_inverse");
    wr_status(32'h30);
    rd_status("err_clear");
    leader(1'b0);
    send_bits(mk(8'($urandom), 8'($urandom)), 5);
    pulse(1'b0, 1300);
    irda = 1'b1;
    idle(20);
    m_err = 1'b1;
    rd_status("timeout_err");
    wr_status(32'h30);
    raw = mk(8'($urandom), 8'($urandom));
    send_frame(raw);
    model_push(raw);
    idle(20);
    rd_status("after_timeout");
    raw = mk(8'($urandom), 8'($urandom));
    leader(1'b0);
    send_bits(raw, 10);
    rst = 1'b1;
    #1;
    chk("midrst_ack", 32'(bus.ack_o), 32'd0);
    chk("midrst_dat", bus.dat_o, 32'd0);
    chk("midrst_int", 32'(intr), 32'd0);
    idle(4);
    rst = 1'b0;
    q.delete();
    m_ie = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_rpt = 8'd0;
    idle(2);
    rd_status("midrst_status");
    send_bits(raw >> 10, 22);
    pulse(1'b0, $urandom_range(44, 50));
    irda = 1'b1;
    idle(20);
    rd_status("remainder_ignored");
    raw = mk(8'($urandom), 8'($urandom));
    send_frame(raw);
    model_push(raw);
    idle(20);
    rd_status("clean_status");
    chk("clean_int_off", 32'(intr), 32'd0);
    rd_data("clean_data");
    rd_status("final_status");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
